// File: rtl/dispatch_ctrl_pkg.sv
// Shared backend defines for the dispatch controller and the debug/perf logic
// that observes it.
package dispatch_ctrl_pkg;

  // Dispatch controller FSM; encoding 3 is unused and recovers to RUN.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RECOVER = 2'd1,
    WALK    = 2'd2
  } DisCtrlState;

  // Drain counter holds FLUSH_CYCLES-1, and FLUSH_CYCLES is at most 15.
  localparam int DrainWidth     = 4;
  localparam int FullStallWidth = 16;

  // The full-stall counter saturates, so a long stall can never wrap back
  // below the timeout threshold.
  function automatic logic [FullStallWidth-1:0] satIncr(
    input logic [FullStallWidth-1:0] value
  );
    return (&value) ? value : value + FullStallWidth'(1);
  endfunction

endpackage

// File: rtl/dispatch_ctrl_sat_counter.sv
// Generic saturating up-counter: counts inc_i cycles and sticks at all-ones.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: step by one unless already saturated.
  always_comb begin
    count_d = count_q;
    if (inc_i && !(&count_q)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/dispatch_ctrl.sv
// Dispatch controller: drives the global dispatch stall and sequences the
// redirect recovery (drain, then ROB walk). It also keeps stall statistics and
// a sticky deadlock flag for a queue-full stall that lasts too long.
module dispatch_ctrl
  import dispatch_ctrl_pkg::*;
#(
  parameter int FETCH_WIDTH  = 4,
  parameter int QUEUE_NUM    = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int TIMEOUT      = 1024
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [FETCH_WIDTH-1:0] ren_valid,
  input  logic [QUEUE_NUM-1:0]   queue_full,
  input  logic                   redirect,
  input  logic                   walk_active,
  input  logic                   walk_done,
  output logic                   dis_full,
  output logic                   ren_ready,
  output logic [1:0]             state_o,
  output logic [31:0]            stall_cnt,
  output logic                   deadlock
);

  localparam logic [DrainWidth-1:0]     DrainLoad   = DrainWidth'(FLUSH_CYCLES - 1);
  localparam logic [FullStallWidth-1:0] TimeoutLast = FullStallWidth'(TIMEOUT - 1);

  DisCtrlState                state_q;
  DisCtrlState                state_d;
  logic [DrainWidth-1:0]      drainCnt_q;
  logic [DrainWidth-1:0]      drainCnt_d;
  logic [FullStallWidth-1:0]  fullStall_q;
  logic [FullStallWidth-1:0]  fullStall_d;
  logic                       deadlock_q;
  logic                       deadlock_d;
  logic                       anyValid;
  logic                       anyFull;
  logic                       fullStallCond;

  assign anyValid      = |ren_valid;
  assign anyFull       = |queue_full;
  assign fullStallCond = (state_q == RUN) && anyFull && anyValid;

  // Stall is same-cycle combinational. While rst is held the FSM is treated
  // as RUN, so an abandoned recovery does not keep dispatch blocked.
  always_comb begin
    dis_full = ((state_q != RUN) && !rst) || redirect || (anyFull && anyValid);
  end

  assign ren_ready = ~dis_full;
  assign state_o   = state_q;
  assign deadlock  = deadlock_q;

  // Next-state logic: redirect restarts the drain from any state and beats walk_done.
  always_comb begin
    state_d    = state_q;
    drainCnt_d = drainCnt_q;
    if (redirect) begin
      state_d    = RECOVER;
      drainCnt_d = DrainLoad;
    end else begin
      case (state_q)
        RUN: begin
          state_d = RUN;
        end
        RECOVER: begin
          if (drainCnt_q == '0) begin
            state_d = walk_active ? WALK : RUN;
          end else begin
            drainCnt_d = drainCnt_q - DrainWidth'(1);
          end
        end
        WALK: begin
          if (walk_done || !walk_active) begin
            state_d = RUN;
          end
        end
        default: begin
          state_d    = RUN;
          drainCnt_d = '0;
        end
      endcase
    end
  end

  // Full-stall timeout: the counter runs only while RUN is blocked by a full
  // queue with real ops waiting. Deadlock is sticky once the threshold is hit.
  always_comb begin
    fullStall_d = '0;
    deadlock_d  = deadlock_q;
    if (fullStallCond) begin
      fullStall_d = satIncr(fullStall_q);
      if (fullStall_q == TimeoutLast) begin
        deadlock_d = 1'b1;
      end
    end
  end

  // State registers with synchronous reset; reset wins over redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      drainCnt_q  <= '0;
      fullStall_q <= '0;
      deadlock_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      drainCnt_q  <= drainCnt_d;
      fullStall_q <= fullStall_d;
      deadlock_q  <= deadlock_d;
    end
  end

  sat_counter #(
    .WIDTH(32)
  ) u_stall_cnt (
    .clk    (clk),
    .rst    (rst),
    .inc_i  (dis_full & anyValid),
    .count_o(stall_cnt)
  );

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed self-checking bench for dispatch_ctrl (FLUSH_CYCLES=2, TIMEOUT=8).
module tb_dispatch_ctrl;

  logic        clk;
  logic        rst;
  logic [3:0]  ren_valid;
  logic [2:0]  queue_full;
  logic        redirect;
  logic        walk_active;
  logic        walk_done;
  logic        dis_full;
  logic        ren_ready;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt;
  logic        deadlock;

  int testsRun;
  int testsFailed;

  dispatch_ctrl #(
    .FETCH_WIDTH (4),
    .QUEUE_NUM   (3),
    .FLUSH_CYCLES(2),
    .TIMEOUT     (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ren_valid  (ren_valid),
    .queue_full (queue_full),
    .redirect   (redirect),
    .walk_active(walk_active),
    .walk_done  (walk_done),
    .dis_full   (dis_full),
    .ren_ready  (ren_ready),
    .state_o    (state_o),
    .stall_cnt  (stall_cnt),
    .deadlock   (deadlock)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change 2 units after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic doReset();
    rst         = 1'b1;
    redirect    = 1'b0;
    walk_active = 1'b0;
    walk_done   = 1'b0;
    ren_valid   = 4'b0000;
    queue_full  = 3'b000;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    ren_valid = 4'b1111;
    #1;
    testsRun++;
    if (dis_full !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_dis_full got %b want 0", dis_full); end
    testsRun++;
    if (ren_ready !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_ren_ready got %b want 1", ren_ready); end
    testsRun++;
    if (state_o !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_state got %0d want 0", state_o); end
    testsRun++;
    if (stall_cnt !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_stall_cnt got %0d want 0", stall_cnt); end
    testsRun++;
    if (deadlock !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_deadlock got %b want 0", deadlock); end
    // Enter RECOVER, then reset mid-recovery.
    redirect = 1'b1;
    tick();
    redirect = 1'b0;
    #1;
    testsRun++;
    if (state_o !== 2'd1) begin testsFailed++; $display("[TB] FAIL reset_pre_recover got %0d want 1", state_o); end
    rst = 1'b1;
    #1;
    testsRun++;
    if (dis_full !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_during_dis_full got %b want 0", dis_full); end
    // Reset wins over a simultaneous redirect.
    redirect = 1'b1;
    tick();
    tick();
    #1;
    testsRun++;
    if (state_o !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_over_redirect got %0d want 0", state_o); end
    testsRun++;
    if (stall_cnt !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_clears_stall got %0d want 0", stall_cnt); end
    rst      = 1'b0;
    redirect = 1'b0;
  endtask

  task automatic test_redirect_run();
    doReset();
    ren_valid = 4'b1111;
    for (int i = 0; i < 9; i++) tick();
    redirect = 1'b1;
    #1;
    testsRun++;
    if (dis_full !== 1'b1) begin testsFailed++; $display("[TB] FAIL redir_c10_dis_full got %b want 1", dis_full); end
    testsRun++;
    if (state_o !== 2'd0) begin testsFailed++; $display("[TB] FAIL redir_c10_state got %0d want 0", state_o); end
    tick();
    redirect = 1'b0;
    #1;
    testsRun++;
    if (dis_full !== 1'b1 || state_o !== 2'd1) begin
      testsFailed++; $display("[TB] FAIL redir_c11 got dis_full=%b state=%0d want 1/1", dis_full, state_o);
    end
    tick();
    #1;
    testsRun++;
    if (dis_full !== 1'b1 || state_o !== 2'd1) begin
      testsFailed++; $display("[TB] FAIL redir_c12 got dis_full=%b state=%0d want 1/1", dis_full, state_o);
    end
    tick();
    #1;
    testsRun++;
    if (dis_full !== 1'b0 || state_o !== 2'd0 || ren_ready !== 1'b1) begin
      testsFailed++; $display("[TB] FAIL redir_c13 got dis_full=%b state=%0d ready=%b want 0/0/1", dis_full, state_o, ren_ready);
    end
    testsRun++;
    if (stall_cnt !== 32'd3) begin testsFailed++; $display("[TB] FAIL redir_stall_cnt got %0d want 3", stall_cnt); end
  endtask

  task automatic test_walk();
    logic [1:0] expState [8];
    expState = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0, 2'd0};
    doReset();
    ren_valid   = 4'b0001;
    walk_active = 1'b1;
    redirect    = 1'b1;
    tick();
    redirect = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) walk_done = 1'b1;
      if (i == 6) begin walk_done = 1'b0; walk_active = 1'b0; end
      #1;
      testsRun++;
      if (state_o !== expState[i]) begin
        testsFailed++; $display("[TB] FAIL walk_state_%0d got %0d want %0d", i, state_o, expState[i]);
      end
      testsRun++;
      if (dis_full !== (expState[i] != 2'd0)) begin
        testsFailed++; $display("[TB] FAIL walk_dis_full_%0d got %b want %b", i, dis_full, expState[i] != 2'd0);
      end
      tick();
    end
  endtask

  task automatic test_redirect_in_walk();
    doReset();
    walk_active = 1'b1;
    redirect    = 1'b1;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    #1;
    testsRun++;
    if (state_o !== 2'd2) begin testsFailed++; $display("[TB] FAIL rw_in_walk got %0d want 2", state_o); end
    redirect  = 1'b1;
    walk_done = 1'b1;
    tick();
    redirect  = 1'b0;
    walk_done = 1'b0;
    #1;
    testsRun++;
    if (state_o !== 2'd1) begin testsFailed++; $display("[TB] FAIL rw_back_recover got %0d want 1", state_o); end
    tick();
    #1;
    testsRun++;
    if (state_o !== 2'd1) begin testsFailed++; $display("[TB] FAIL rw_counter_reload got %0d want 1", state_o); end
    tick();
    #1;
    testsRun++;
    if (state_o !== 2'd2) begin testsFailed++; $display("[TB] FAIL rw_rewalk got %0d want 2", state_o); end
    walk_active = 1'b0;
    tick();
    #1;
    testsRun++;
    if (state_o !== 2'd0) begin testsFailed++; $display("[TB] FAIL rw_done got %0d want 0", state_o); end
  endtask

  task automatic test_deadlock();
    doReset();
    ren_valid  = 4'b0001;
    queue_full = 3'b010;
    for (int i = 0; i < 5; i++) tick();
    // No valid ops: no stall counted and the timeout progress clears.
    ren_valid  = 4'b0000;
    queue_full = 3'b111;
    #1;
    testsRun++;
    if (dis_full !== 1'b0) begin testsFailed++; $display("[TB] FAIL nv_dis_full got %b want 0", dis_full); end
    for (int i = 0; i < 20; i++) tick();
    #1;
    testsRun++;
    if (stall_cnt !== 32'd5 || state_o !== 2'd0) begin
      testsFailed++; $display("[TB] FAIL nv_stall_cnt got %0d state=%0d want 5/0", stall_cnt, state_o);
    end
    ren_valid  = 4'b0001;
    queue_full = 3'b010;
    for (int i = 0; i < 7; i++) tick();
    #1;
    testsRun++;
    if (deadlock !== 1'b0) begin testsFailed++; $display("[TB] FAIL dl_after7 got %b want 0", deadlock); end
    testsRun++;
    if (dis_full !== 1'b1) begin testsFailed++; $display("[TB] FAIL dl_dis_full got %b want 1", dis_full); end
    tick();
    #1;
    testsRun++;
    if (deadlock !== 1'b1) begin testsFailed++; $display("[TB] FAIL dl_after8 got %b want 1", deadlock); end
    queue_full = 3'b000;
    tick();
    tick();
    #1;
    testsRun++;
    if (deadlock !== 1'b1) begin testsFailed++; $display("[TB] FAIL dl_sticky got %b want 1", deadlock); end
    testsRun++;
    if (stall_cnt !== 32'd13) begin testsFailed++; $display("[TB] FAIL dl_stall_cnt got %0d want 13", stall_cnt); end
  endtask

  task automatic test_saturate();
    doReset();
    force dut.u_stall_cnt.count_q = 32'hFFFF_FFFE;
    #1;
    release dut.u_stall_cnt.count_q;
    ren_valid  = 4'b0100;
    queue_full = 3'b001;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      testsRun++;
      if (stall_cnt !== 32'hFFFF_FFFF) begin
        testsFailed++; $display("[TB] FAIL sat_cycle_%0d got %h want ffffffff", i, stall_cnt);
      end
    end
    ren_valid  = 4'b0000;
    queue_full = 3'b000;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst         = 1'b1;
    redirect    = 1'b0;
    walk_active = 1'b0;
    walk_done   = 1'b0;
    ren_valid   = 4'b0000;
    queue_full  = 3'b000;
    test_reset();
    test_redirect_run();
    test_walk();
    test_redirect_in_walk();
    test_deadlock();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
